// File: rtl/visibility_buffer_if.sv
// visibility_buffer_if: input visibility stream, output byte stream and drop status.
interface visibility_buffer_if #(parameter int WIDTH = 36);
    logic             valid_i;
    logic [WIDTH-1:0] revis_i;
    logic [WIDTH-1:0] imvis_i;
    logic             last_i;
    logic             m_tvalid;
    logic             m_tready;
    logic [7:0]       m_tdata;
    logic             m_tlast;
    logic             overflow_o;
    logic             lenerr_o;
    logic [7:0]       dropped_o;
    modport master (
        output valid_i, revis_i, imvis_i, last_i, m_tready,
        input  m_tvalid, m_tdata, m_tlast, overflow_o, lenerr_o, dropped_o
    );
    modport slave (
        input  valid_i, revis_i, imvis_i, last_i, m_tready,
        output m_tvalid, m_tdata, m_tlast, overflow_o, lenerr_o, dropped_o
    );
endinterface

// File: rtl/visibility_buffer.sv
// visibility_buffer: two-bank frame buffer that stores whole visibility frames and
// drains them as a little-endian byte stream, dropping frames that cannot be stored.
module visibility_buffer #(
    parameter int CORES = 18,
    parameter int TRATE = 30,
    parameter int WIDTH = 36
) (
    input logic                clock,
    input logic                reset,
    visibility_buffer_if.slave bus
);
    localparam int PAIRS = CORES * TRATE;
    localparam int ABITS = $clog2(PAIRS);
    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int NB    = 2 * BYTES;
    localparam int BBITS = $clog2(NB);
    localparam int EB    = 8 * BYTES;
    localparam logic [ABITS-1:0] LAST_A  = ABITS'(PAIRS - 1);
    localparam logic [BBITS-1:0] LAST_B  = BBITS'(NB - 1);
    localparam logic [ABITS:0]   PAIRS_A = (ABITS + 1)'(PAIRS);

    typedef enum logic {FILL, DISCARD} wstate_t;
    typedef enum logic [1:0] {IDLE, PRIME, SEND} rstate_t;

    wstate_t          ws_q, ws_d;
    rstate_t          rs_q, rs_d;
    logic [1:0]       full_q, full_d;
    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ABITS-1:0] waddr_q, waddr_d, vidx_q, vidx_d;
    logic [ABITS:0]   raddr_q, raddr_d;
    logic [BBITS-1:0] bcnt_q, bcnt_d;
    logic [2*EB-1:0]  sh_q, sh_d;
    logic             tvalid_q, tvalid_d, ovf_q, ovf_d, len_q, len_d;
    logic [7:0]       dropped_q, dropped_d;
    logic             we, rd_go, rd_en, rd_clr, wr_set, drop, free, xfer;

    logic [2*WIDTH-1:0] mem [2][PAIRS];
    logic [2*WIDTH-1:0] rdata_q;
    logic [EB-1:0]      re_x, im_x;

    assign re_x = EB'($signed(rdata_q[WIDTH-1:0]));
    assign im_x = EB'($signed(rdata_q[2*WIDTH-1:WIDTH]));

    always_ff @(posedge clock) begin
        if (we && !reset) mem[wbank_q][waddr_q] <= {bus.imvis_i, bus.revis_i};
        if (rd_en) rdata_q <= mem[rbank_q][raddr_q[ABITS-1:0]];
    end

    always_comb begin
        rs_d     = rs_q;
        rbank_d  = rbank_q;
        vidx_d   = vidx_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        tvalid_d = tvalid_q;
        rd_go    = 1'b0;
        rd_clr   = 1'b0;
        xfer     = tvalid_q && bus.m_tready;
        case (rs_q)
            IDLE: if (full_q[rbank_q]) begin
                rd_go = 1'b1;
                rs_d  = PRIME;
            end
            PRIME: begin
                sh_d     = {im_x, re_x};
                rd_go    = 1'b1;
                tvalid_d = 1'b1;
                vidx_d   = '0;
                bcnt_d   = '0;
                rs_d     = SEND;
            end
            default: if (xfer) begin
                if (bcnt_q != LAST_B) begin
                    sh_d   = sh_q >> 8;
                    bcnt_d = bcnt_q + 1'b1;
                end else if (vidx_q == LAST_A) begin
                    rd_clr   = 1'b1;
                    rbank_d  = ~rbank_q;
                    tvalid_d = 1'b0;
                    rs_d     = IDLE;
                end else begin
                    // word for vidx+1 was prefetched when vidx was loaded
                    sh_d   = {im_x, re_x};
                    vidx_d = vidx_q + 1'b1;
                    bcnt_d = '0;
                    rd_go  = 1'b1;
                end
            end
        endcase
        rd_en   = rd_go && (raddr_q < PAIRS_A);
        raddr_d = rd_clr ? '0 : raddr_q + {{ABITS{1'b0}}, rd_en};
        ws_d    = ws_q;
        wbank_d = wbank_q;
        waddr_d = waddr_q;
        we      = 1'b0;
        wr_set  = 1'b0;
        drop    = 1'b0;
        ovf_d   = ovf_q;
        len_d   = len_q;
        // a bank being released this cycle may be refilled at once
        free    = !full_q[wbank_q] || (rd_clr && rbank_q == wbank_q);
        if (bus.valid_i) begin
            if (ws_q == DISCARD) begin
                if (bus.last_i) begin
                    ws_d    = FILL;
                    waddr_d = '0;
                end
            end else if (waddr_q == '0 && !free) begin
                ovf_d = 1'b1;
                drop  = 1'b1;
                ws_d  = bus.last_i ? FILL : DISCARD;
            end else begin
                we = 1'b1;
                if (waddr_q == LAST_A) begin
                    waddr_d = '0;
                    wr_set  = bus.last_i;
                    wbank_d = bus.last_i ? ~wbank_q : wbank_q;
                    len_d   = len_q | !bus.last_i;
                    drop    = !bus.last_i;
                    ws_d    = bus.last_i ? FILL : DISCARD;
                end else if (bus.last_i) begin
                    len_d   = 1'b1;
                    drop    = 1'b1;
                    waddr_d = '0;
                end else begin
                    waddr_d = waddr_q + 1'b1;
                end
            end
        end
        full_d = full_q;
        if (rd_clr) full_d[rbank_q] = 1'b0;
        if (wr_set) full_d[wbank_q] = 1'b1;
        dropped_d = (drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ws_q      <= FILL;
            rs_q      <= IDLE;
            full_q    <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            vidx_q    <= '0;
            bcnt_q    <= '0;
            sh_q      <= '0;
            tvalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
            len_q     <= 1'b0;
            dropped_q <= '0;
        end else begin
            ws_q      <= ws_d;
            rs_q      <= rs_d;
            full_q    <= full_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            vidx_q    <= vidx_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            tvalid_q  <= tvalid_d;
            ovf_q     <= ovf_d;
            len_q     <= len_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.m_tvalid   = tvalid_q;
    assign bus.m_tdata    = sh_q[7:0];
    assign bus.m_tlast    = tvalid_q && vidx_q == LAST_A && bcnt_q == LAST_B;
    assign bus.overflow_o = ovf_q;
    assign bus.lenerr_o   = len_q;
    assign bus.dropped_o  = dropped_q;
endmodule

// File: tb/tb_visibility_buffer.sv
// tb_visibility_buffer: directed checks of capture, drain, drop and reset behaviour
// with CORES=2, TRATE=2, WIDTH=12 (4 visibilities, 16 bytes per frame).
module tb_visibility_buffer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] got [64];
    logic       gl [64];
    int         gc [64];
    logic [7:0] t1 [16] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'hFF,
                            8'h03, 8'h00, 8'hFD, 8'hFF, 8'h04, 8'h00, 8'hFC, 8'hFF};

    visibility_buffer_if #(.WIDTH(12)) bus ();
    visibility_buffer #(.CORES(2), .TRATE(2), .WIDTH(12)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // byte i of a frame whose visibility k (1-based) is re=base+k, im=-(base+k)
    function automatic logic [7:0] mbyte(input int base, input int i);
        logic [11:0] r, m;
        logic [15:0] r16, m16;
        r   = 12'(base + i / 4 + 1);
        m   = 12'(-(base + i / 4 + 1));
        r16 = {{4{r[11]}}, r};
        m16 = {{4{m[11]}}, m};
        case (i % 4)
            0:       return r16[7:0];
            1:       return r16[15:8];
            2:       return m16[7:0];
            default: return m16[15:8];
        endcase
    endfunction

    task automatic send_frame(input int base, input int n, input int last_at);
        for (int k = 1; k <= n; k++) begin
            bus.valid_i = 1'b1;
            bus.revis_i = 12'(base + k);
            bus.imvis_i = 12'(-(base + k));
            bus.last_i  = (k == last_at);
            @(negedge clock);
        end
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic collect(input int n, input bit tog);
        int cnt = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] hold = '0;
        while (cnt < n && cyc < 400) begin
            bus.m_tready = tog ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                chk("stall_valid", 32'(bus.m_tvalid), 32'd1);
                chk("stall_data", 32'(bus.m_tdata), 32'(hold));
            end
            stalled = 1'b0;
            if (bus.m_tvalid && bus.m_tready) begin
                got[cnt] = bus.m_tdata;
                gl[cnt]  = bus.m_tlast;
                gc[cnt]  = cyc;
                cnt++;
            end else if (bus.m_tvalid) begin
                stalled = 1'b1;
                hold    = bus.m_tdata;
            end
            @(negedge clock);
            cyc++;
        end
        chk("collect_count", 32'(cnt), 32'(n));
    endtask

    task automatic chk_frame(input string tag, input int off, input int base);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[off+i]), 32'(mbyte(base, i)));
            chk($sformatf("%s_last%0d", tag, i), 32'(gl[off+i]), 32'(i == 15));
        end
    endtask

    task automatic chk_t1(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(t1[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(gl[i]), 32'(i == 15));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(bus.m_tvalid), 32'd0);
        chk({tag, "_tlast"}, 32'(bus.m_tlast), 32'd0);
        chk({tag, "_tdata"}, 32'(bus.m_tdata), 32'd0);
        chk({tag, "_overflow"}, 32'(bus.overflow_o), 32'd0);
        chk({tag, "_lenerr"}, 32'(bus.lenerr_o), 32'd0);
        chk({tag, "_dropped"}, 32'(bus.dropped_o), 32'd0);
    endtask

    task automatic chk_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(bus.m_tvalid), 32'd0);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.valid_i  = 1'b0;
        bus.revis_i  = '0;
        bus.imvis_i  = '0;
        bus.last_i   = 1'b0;
        bus.m_tready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;

        // basic frame and latency
        bus.m_tready = 1'b1;
        send_frame(0, 4, 4);
        chk("lat_n0", 32'(bus.m_tvalid), 32'd0);
        @(negedge clock);
        chk("lat_n1", 32'(bus.m_tvalid), 32'd0);
        @(negedge clock);
        chk("lat_n2", 32'(bus.m_tvalid), 32'd1);
        collect(16, 1'b0);
        chk_t1("basic");
        chk_quiet("basic_after", 3);

        // back-pressure
        bus.m_tready = 1'b0;
        send_frame(0, 4, 4);
        collect(16, 1'b1);
        chk_t1("bp");
        chk("bp_dropped", 32'(bus.dropped_o), 32'd0);

        // overflow: three frames against a stalled reader
        do_reset();
        bus.m_tready = 1'b0;
        send_frame(16, 4, 4);
        send_frame(32, 4, 4);
        send_frame(48, 4, 4);
        chk("ovf_flag", 32'(bus.overflow_o), 32'd1);
        chk("ovf_dropped", 32'(bus.dropped_o), 32'd1);
        chk("ovf_lenerr", 32'(bus.lenerr_o), 32'd0);
        collect(32, 1'b0);
        chk_frame("ovf_f1", 0, 16);
        chk_frame("ovf_f2", 16, 32);
        chk("ovf_gap", 32'(gc[16] - gc[15]), 32'd3);
        chk_quiet("ovf_after", 6);

        // length errors
        do_reset();
        bus.m_tready = 1'b1;
        send_frame(64, 3, 3);
        chk("len_short_flag", 32'(bus.lenerr_o), 32'd1);
        chk("len_short_dropped", 32'(bus.dropped_o), 32'd1);
        chk_quiet("len_short_quiet", 4);
        send_frame(2044, 4, 4);
        collect(16, 1'b0);
        chk_frame("len_good", 0, 2044);
        send_frame(96, 5, 5);
        chk("len_long_dropped", 32'(bus.dropped_o), 32'd2);
        chk("len_long_ovf", 32'(bus.overflow_o), 32'd0);
        chk_quiet("len_long_quiet", 4);

        // bank 0 freed on the same edge the next frame starts into it
        do_reset();
        bus.m_tready = 1'b0;
        send_frame(112, 4, 4);
        send_frame(128, 4, 4);
        collect(15, 1'b0);
        chk("sim_pre_last", 32'(bus.m_tlast), 32'd1);
        chk("sim_pre_data", 32'(bus.m_tdata), 32'(mbyte(112, 15)));
        fork
            send_frame(144, 4, 4);
            collect(33, 1'b0);
        join
        chk("sim_a_byte15", 32'(got[0]), 32'(mbyte(112, 15)));
        chk("sim_a_last", 32'(gl[0]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("sim_b_byte%0d", i), 32'(got[1+i]), 32'(mbyte(128, i)));
            chk($sformatf("sim_c_byte%0d", i), 32'(got[17+i]), 32'(mbyte(144, i)));
        end
        chk("sim_c_last", 32'(gl[32]), 32'd1);
        chk("sim_dropped", 32'(bus.dropped_o), 32'd0);
        chk("sim_overflow", 32'(bus.overflow_o), 32'd0);

        // mid-frame reset
        do_reset();
        bus.m_tready = 1'b1;
        send_frame(200, 2, 2);
        chk("mrst_pre_lenerr", 32'(bus.lenerr_o), 32'd1);
        chk("mrst_pre_dropped", 32'(bus.dropped_o), 32'd1);
        send_frame(160, 4, 4);
        collect(6, 1'b0);
        chk("mrst_byte7_valid", 32'(bus.m_tvalid), 32'd1);
        chk("mrst_byte7_data", 32'(bus.m_tdata), 32'(mbyte(160, 6)));
        do_reset();
        chk_zero("mrst");
        chk_quiet("mrst_quiet", 4);
        send_frame(176, 4, 4);
        collect(16, 1'b0);
        chk_frame("mrst_new", 0, 176);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/visibility_buffer.md
# visibility_buffer

Ping-pong frame buffer that sits directly downstream of the visibility accumulator. It captures each completed frame of `PAIRS` full-width visibilities, which arrive as an un-throttled valid/last stream. It then serialises the frame as a little-endian byte stream with a valid/ready handshake toward the readout interface (SPI/USB bridge). Two banks let one frame drain under back-pressure while the next fills. Frames that cannot be stored are dropped whole and counted.

## Interface
- `CORES`, 18: first-stage correlator cores.
- `TRATE`, 30: time-multiplexing rate per core. `PAIRS = CORES*TRATE` visibilities per frame; `ABITS = $clog2(PAIRS)`.
- `WIDTH`, 36: visibility bit-width. `BYTES = (WIDTH+7)/8` bytes per component.

- `clock` in 1: single clock domain.
- `reset` in 1: synchronous reset, active-high.
- `valid_i` in 1: input beat valid. It is always accepted; there is no back-pressure.
- `revis_i` in WIDTH: real component, two's complement.
- `imvis_i` in WIDTH: imaginary component, two's complement.
- `last_i` in 1: marks the final beat of a frame.
- `m_tvalid` out 1: output byte valid.
- `m_tready` in 1: consumer ready.
- `m_tdata` out 8: output byte.
- `m_tlast` out 1: marks the final byte of a frame.
- `overflow_o` out 1: sticky; set when a frame is dropped because no bank was free.
- `lenerr_o` out 1: sticky; set when a frame has the wrong length.
- `dropped_o` out 8: count of dropped frames (overflow or length error), saturating at 255.

## Operation
**Storage**
- Two banks, each `PAIRS` x `2*WIDTH`, with 1-cycle registered read.
- Each bank has a `full` flag.

**Writer**
- States: FILL, DISCARD.
- FILL:
  - Each `valid_i` beat writes `{imvis_i, revis_i}` to `wbank[waddr]` and increments `waddr`.
  - Beat with `last_i` at `waddr == PAIRS-1`: set `full[wbank]`, toggle `wbank`, clear `waddr`.
  - `last_i` at any other `waddr`: set `lenerr_o`, increment `dropped_o`, clear `waddr`, keep `wbank`. The frame is discarded.
  - Beat at `waddr == PAIRS-1` without `last_i`: same as a length error. Go to DISCARD.
- Frame start with `full[wbank]` set: go to DISCARD, set `overflow_o`, increment `dropped_o`.
- DISCARD: ignore beats until a beat with `last_i`, then clear `waddr` and return to FILL.
- Each dropped frame is counted exactly once.

**Reader**
- States: IDLE, PRIME, SEND.
- IDLE: if `full[rbank]`, issue a read of address 0 and go to PRIME.
- PRIME: load the read word into the shift register and go to SEND.
- SEND:
  - Byte order per visibility: the re bytes LSB-first, then the im bytes LSB-first, `2*BYTES` bytes in total.
  - Each component is sign-extended to `8*BYTES` bits.
  - The next word is prefetched, so there are no bubbles between visibilities while `m_tready` stays high.
  - `m_tlast` is high on the final byte of visibility `PAIRS-1`.
  - When the `m_tlast` byte is accepted: clear `full[rbank]`, toggle `rbank`, return to IDLE.

**Handshake**
- A byte transfers on a rising edge where `m_tvalid && m_tready`.
- Once raised, `m_tvalid` and `m_tdata` stay stable until the byte transfers.
- `m_tvalid` does not depend combinationally on `m_tready`.

**Simultaneous events**
- The writer setting `full` on one bank and the reader clearing `full` on the other bank in the same cycle are both honoured.
- The reader clearing `full[b]` in the same cycle the writer starts a frame into `b`: the frame is accepted. A freed bank counts as free in that cycle.

**Reset** (any time)
- `full` = 00; `wbank`, `rbank`, `waddr` = 0.
- Writer goes to FILL, reader to IDLE.
- `m_tvalid`, `m_tlast`, `overflow_o`, `lenerr_o` = 0; `dropped_o` = 0; `m_tdata` = 0.
- Any partial or stored frame is lost.
- Input beats in the reset cycle are ignored.

## Timing
- Latency: `m_tvalid` rises after the 2nd rising edge following the edge that samples an accepted `last_i` beat, if the reader was IDLE.
- Throughput: one byte per cycle within a frame under continuous `m_tready`.
- Between frames there are exactly 2 idle cycles (IDLE, PRIME) when the next bank is already full.
- Write-to-read hazard: none. The reader never touches a bank that is not `full`.

## Test plan
Bench parameters: `CORES=2`, `TRATE=2`, `WIDTH=12`, giving `PAIRS=4`, `BYTES=2`, 16 bytes per frame.

1. **Basic frame.** Send re=k, im=-k for k=1..4, with `last_i` on k=4, `m_tready`=1.
   - Required: 16 bytes `01 00 FF FF 02 00 FE FF 03 00 FD FF 04 00 FC FF`.
   - `m_tlast` only on byte 16; first `m_tvalid` 2 cycles after the last sampled edge.
2. **Back-pressure.** Same frame with `m_tready` toggling 1,0,1,0.
   - Required: identical byte sequence, with `m_tdata` stable while stalled.
3. **Overflow.** `m_tready`=0; send 3 back-to-back frames.
   - Required: `overflow_o`=1, `dropped_o`=1.
   - With `m_tready` then 1: frames 1 and 2 are output in order, each followed by 2 idle cycles.
4. **Length error.**
   - `last_i` on the 3rd beat: `lenerr_o`=1, `dropped_o`=1, no output.
   - A following correct frame is output intact.
   - 5 beats with `last_i` on the 5th: `dropped_o`=2.
5. **Simultaneous free and fill.** Accept the `m_tlast` byte of bank 0 on the same edge that the first beat of the frame after bank 1 arrives.
   - Required: no drop; that frame is stored in bank 0.
6. **Mid-frame reset.** Assert `reset` for 1 cycle during byte 7 of a frame.
   - Required: all outputs 0 the next cycle.
   - A new frame then outputs fully from byte 1.
